// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-back queue.
package wb_pkg;
  localparam int AW = 5;
  localparam int DW = 32;

  // Writes to this index are dropped so r0 stays zero.
  localparam logic [AW-1:0] REG_ZERO = '0;

  // One buffered write-back.
  typedef struct packed {
    logic [AW-1:0] rg;
    logic [DW-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/regfile_wb_queue_if.sv
// Producer handshake plus register-file write bus of the write-back queue.
interface regfile_wb_queue_if;
  import wb_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_reg;
  logic [DW-1:0] in_data;
  logic          write;
  logic [AW-1:0] write_reg;
  logic [DW-1:0] write_data;

  modport master (
    output in_valid, in_reg, in_data,
    input  in_ready, write, write_reg, write_data
  );

  modport slave (
    input  in_valid, in_reg, in_data,
    output in_ready, write, write_reg, write_data
  );
endinterface

// File: rtl/wbq_lookup.sv
// Bypass lookup: finds the youngest occupied queue entry for one register index.
module wbq_lookup
  import wb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  wb_entry_t         ent [DEPTH],
  input  logic [PW-1:0]     rd_ptr,
  input  logic [CW-1:0]     count,
  input  logic [AW-1:0]     lk_reg,
  output logic              hit,
  output logic [DW-1:0]     data
);

  // Walk oldest to youngest; later matches overwrite, so the youngest wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count) && (lk_reg != REG_ZERO) &&
          (ent[rd_ptr + PW'(i)].rg == lk_reg)) begin
        hit  = 1'b1;
        data = ent[rd_ptr + PW'(i)].data;
      end
    end
  end
endmodule

// File: rtl/regfile_wb_queue.sv
// In-order write-back queue feeding the register file's single write port.
// Optional bypass lookup built when WBQ_BYPASS_EN is defined; otherwise the
// lookup outputs are tied to zero.
module regfile_wb_queue
  import wb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  regfile_wb_queue_if.slave  bus,
  input  logic               hold,
  input  logic [AW-1:0]      lk_reg1,
  input  logic [AW-1:0]      lk_reg2,
  output logic               lk_hit1,
  output logic [DW-1:0]      lk_data1,
  output logic               lk_hit2,
  output logic [DW-1:0]      lk_data2,
  output logic [CW-1:0]      count,
  output logic               empty
);

  wb_entry_t     mem_q [DEPTH];
  wb_entry_t     mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          accept, push, pop;
  wb_entry_t     head;

  assign count        = count_q;
  assign empty        = (count_q == '0);
  // Ready ignores a same-cycle pop: no pass-through when full.
  assign bus.in_ready = (count_q != CW'(DEPTH));
  assign accept       = bus.in_valid && bus.in_ready;
  // r0 writes complete the handshake but are never stored.
  assign push         = accept && (bus.in_reg != REG_ZERO);
  assign pop          = !empty && !hold;

  assign head           = mem_q[rd_ptr_q];
  assign bus.write      = pop;
  assign bus.write_reg  = empty ? '0 : head.rg;
  assign bus.write_data = empty ? '0 : head.data;

  // Next-state: store at tail, advance pointers, track occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{rg: bus.in_reg, data: bus.in_data};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state; reset drops anything pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef WBQ_BYPASS_EN
  wbq_lookup #(.DEPTH(DEPTH)) u_lk1 (
    .ent(mem_q), .rd_ptr(rd_ptr_q), .count(count_q),
    .lk_reg(lk_reg1), .hit(lk_hit1), .data(lk_data1)
  );
  wbq_lookup #(.DEPTH(DEPTH)) u_lk2 (
    .ent(mem_q), .rd_ptr(rd_ptr_q), .count(count_q),
    .lk_reg(lk_reg2), .hit(lk_hit2), .data(lk_data2)
  );
`else
  // Lookup disabled: outputs idle, indices ignored.
  logic unused_lk;
  assign unused_lk = ^{lk_reg1, lk_reg2};
  assign lk_hit1   = 1'b0;
  assign lk_data1  = '0;
  assign lk_hit2   = 1'b0;
  assign lk_data2  = '0;
`endif
endmodule

// File: doc/regfile_wb_queue.md
Name: regfile_wb_queue

Overview:
- Write-back queue on the producer side of the 32x32 register file's single write port.
- Buffers results from the execute/memory stages and drains them in order, one per cycle, onto the register file's write/write_reg/write_data inputs.
- Discards writes to r0, so r0 stays architecturally zero.
- Optionally exposes a two-port bypass lookup, so decode can read values that are still pending.

Parameters:
DEPTH, 4, queue entries; power of two, minimum 2
AW, 5, register index width
DW, 32, data width

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  producer presents a result
in_ready  output  1  queue can accept; transfer occurs when in_valid && in_ready at the clock edge
in_reg  input  AW  destination register
in_data  input  DW  result value
hold  input  1  inhibit draining this cycle (write port borrowed elsewhere)
write  output  1  register-file write enable
write_reg  output  AW  register-file write index
write_data  output  DW  register-file write data
lk_reg1  input  AW  bypass lookup index, port 1
lk_reg2  input  AW  bypass lookup index, port 2
lk_hit1  output  1  a pending entry matches lk_reg1
lk_data1  output  DW  data of the youngest matching entry for port 1
lk_hit2  output  1  a pending entry matches lk_reg2
lk_data2  output  DW  data of the youngest matching entry for port 2
count  output  $clog2(DEPTH)+1  number of occupied entries
empty  output  1  count == 0

Behaviour:
- Storage: circular buffer of DEPTH entries {reg, data}.
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - count is registered.
- Reset (async, rst_n low):
  - wr_ptr = rd_ptr = count = 0; empty = 1; write = 0.
  - Entry contents are don't-care.
  - Pending entries at reset are lost; no partial drain.
- in_ready = (count != DEPTH). It is not dependent on same-cycle pop: no pass-through when full.
- Push:
  - Condition: in_valid && in_ready && in_reg != 0 → store at wr_ptr, wr_ptr+1.
  - in_valid && in_ready && in_reg == 0 → handshake completes, nothing stored, count unchanged.
- Drain (combinational from head):
  - write = !empty && !hold.
  - write_reg and write_data = head entry; they are 0 when empty.
  - Pop occurs when write = 1 at the edge: rd_ptr+1.
  - Draining order is strict FIFO, so the latest write to a register lands last.
- Simultaneous push and pop: count unchanged, both pointers advance.
  - When empty, a push is not visible on write until the next cycle.
  - Minimum latency from accepted input to register-file update is 2 edges.
- hold = 1: head remains stable, no pop; pushes still accepted while count < DEPTH.
- Boundaries:
  - count saturates naturally at DEPTH because in_ready is low.
  - Pointer wrap at DEPTH-1 → 0 must preserve order.
- Lookup:
  - Searches only occupied entries, i.e. state before the current edge.
  - A same-cycle incoming push is not matched.
  - On multiple matches, the youngest (closest to wr_ptr) wins.
  - lk_reg == 0 → hit = 0.
  - No match → hit = 0, data = 0.
  - Purely combinational.

Optional Feature:
- Macro: WBQ_BYPASS_EN.
- Defined: the lookup logic above is built.
- Undefined:
  - lk_hit1 and lk_hit2 are tied 0; lk_data1 and lk_data2 are tied 0.
  - lk_reg inputs are unused.
  - No comparators are synthesized.
  - All other behaviour is identical.

Decomposition:
- Shared package (wb_pkg): the AW and DW constants; the wb_entry_t typedef {reg[AW-1:0], data[DW-1:0]}; REG_ZERO = 0.
- Sub-module wbq_lookup: priority match of one lookup index over the entry array given rd_ptr and count. Instantiated twice under WBQ_BYPASS_EN.

Test Plan:
- Reset, then push (r5, 0xDEADBEEF) with hold = 0 → next cycle write = 1, write_reg = 5, write_data = 0xDEADBEEF; one cycle later empty = 1, write = 0.
- Hold = 1, push r1..r4 with values 1..4 → in_ready = 0 after the 4th push, count = 4. Release hold → writes r1..r4 in order on 4 consecutive cycles, with in_ready = 1 after the first pop.
- Push (r0, 0x1234) → in_ready = 1, count stays 0, write never asserted.
- Hold = 1, push (r7, 0xA) then (r7, 0xB) → lk_reg1 = 7 gives lk_hit1 = 1, lk_data1 = 0xB; lk_reg2 = 9 gives lk_hit2 = 0, lk_data2 = 0.
- Streaming: push on every cycle for 10 cycles, hold = 0 → count stays ≤ 1, all 10 writes emitted in order, pointer wrap exercised.
- Hold = 1, count = 3, assert rst_n low asynchronously mid-cycle → count = 0, empty = 1, write = 0 immediately, before the next edge.
